commit_trace_tx: RTL
====================

Name: commit_trace_tx

Overview:
- Transmit side of the retirement-trace path for the 16-bit pipelined CPU.
- Captures one commit event per cycle from the writeback boundary: reg write, load, store, branch/NOP or halt.
- Buffers commit events in a small FIFO and serializes each one into a variable-length record of 16-bit words on a valid/ready stream.
- A trace sink or off-chip logger reconstructs the INUM/PC/REG/ADDR/VALUE trace lines from these records.

Parameters:
DEPTH, 4, record FIFO entries; power of 2, minimum 2.
CNT_W, 16, width of the instruction counter; its low 8 bits go into the header.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
commit_valid  in  1  one instruction retires this cycle
commit_pc  in  16  PC of the retiring instruction
commit_regwrite  in  1  register file written
commit_reg  in  4  destination register
commit_wdata  in  16  register write data
commit_memread  in  1  load
commit_memwrite  in  1  store
commit_addr  in  16  memory address
commit_mdata  in  16  store data
commit_halt  in  1  HLT retiring
commit_stall  out  1  FIFO full; pipeline must hold its commit
tx_valid  out  1  tx_data valid
tx_data  out  16  record word
tx_ready  in  1  sink accepts word
overflow  out  1  sticky: a commit was dropped
done  out  1  halt record fully sent

Behaviour:
- Reset values (rst_n=0 at posedge): FIFO empty, FSM IDLE, inst counter 0, tx_valid=0, tx_data=0, overflow=0, done=0. Reset mid-record aborts the record with no further words.
- Classification, first match wins:
  - commit_halt -> HALT (type F)
  - regwrite & memread -> LOAD (2)
  - regwrite -> REG (1)
  - memwrite -> STORE (3)
  - otherwise -> NOP (0)
- Header word: [15:12] type, [11:8] reg (0 for NOP/STORE/HALT), [7:0] inum[7:0].
- Record words, in order:
  - NOP: hdr, pc
  - REG: hdr, pc, wdata
  - LOAD: hdr, pc, wdata, addr
  - STORE: hdr, pc, addr, mdata
  - HALT: hdr, pc, inum[15:0] (zero-extended or truncated to 16 bits)
- inum: value of the counter when the commit is accepted. The counter increments by 1 on every accepted commit and wraps modulo 2^CNT_W.
- Accept rule: commit_valid & !full & !halt_seen. The accepted event is pushed with its type and inum.
- commit_valid while full: the event is dropped, overflow set (sticky), counter unchanged.
- commit_stall = full, computed from the occupancy register only. A push is blocked when full even if a pop happens in the same cycle.
- halt_seen is set on acceptance of HALT. Later commit_valid is ignored silently: no overflow, no count.
- FSM states: IDLE, HDR, W1, W2, W3, DONE.
  - IDLE with FIFO non-empty: pop the head into the serializer register, drive the header, tx_valid=1, go to HDR.
  - Each tx_valid & tx_ready advances one word. After the last word of the record: go to IDLE, or pop the next record directly with no bubble if the FIFO is non-empty.
  - After the last HALT word is accepted: DONE. There done=1 and tx_valid=0 until reset.
- Latency: a commit accepted at edge T into an empty FIFO with FSM IDLE gives its header with tx_valid=1 after edge T+1. Peak throughput is one word per cycle.
- Stream rule: while tx_valid & !tx_ready, tx_data and tx_valid hold stable. tx_valid never drops without a handshake.
- Push and pop in the same cycle (not full): occupancy unchanged, order preserved.
- Pointers are log2(DEPTH) bits and wrap naturally. A separate count register, 0..DEPTH, gives full and empty.

Test Plan:
- REG then NOP, tx_ready=1: commit {pc=0x0002, regwrite, reg=3, wdata=0x1234}, then {pc=0x0004, plain} -> words 0x1300, 0x0002, 0x1234, 0x0001, 0x0004 on consecutive cycles with no bubble.
- LOAD and STORE field order: load {pc=0x10, reg=5, wdata=0xBEEF, addr=0x0040} -> 0x2500, 0x0010, 0xBEEF, 0x0040; store {pc=0x12, addr=0x0042, mdata=0x00AA} -> 0x3001, 0x0012, 0x0042, 0x00AA.
- Backpressure/full: tx_ready=0, 6 consecutive commits with DEPTH=4 and the stall ignored -> first record at the output, then 4 held in the FIFO. commit_stall=1 once count=4, the 6th commit is dropped, overflow=1, and the inum sequence seen later is 0..4. Each word stays stable while tx_ready=0.
- HALT: three NOPs then HALT at pc=0x0020, followed by more commit_valid -> HALT record 0xF003, 0x0020, 0x0003. done=1 after its last handshake, nothing further is sent, overflow=0.
- Counter wrap: with CNT_W=8, after 256 accepted commits the next header low byte is 0x00.
- Reset mid-record: assert rst_n=0 after word 2 of a LOAD record -> next cycle tx_valid=0, overflow=0, done=0, FIFO empty. The next commit header carries inum 0.

Source files
------------

// File: rtl/commit_trace_tx.sv
// -----------------------------------------------------------------------------
// commit_trace_tx
// Transmit side of the retirement-trace path. Every retiring instruction is
// classified (HALT / LOAD / REG / STORE / NOP), stamped with the running
// instruction number and pushed into a small record FIFO. A serializer pops
// records and streams them as 2..4 16-bit words on a valid/ready interface:
//    NOP  : hdr, pc
//    REG  : hdr, pc, wdata
//    LOAD : hdr, pc, wdata, addr
//    STORE: hdr, pc, addr, mdata
//    HALT : hdr, pc, inum[15:0]
// Header word = {type[3:0], reg[3:0], inum[7:0]}.
//
// Ports
//    clk, rst_n        clock, synchronous active-low reset
//    commit_*          retirement event from the writeback boundary
//    commit_stall      record FIFO full; the pipeline must hold its commit
//    tx_valid/tx_data  record word stream, held stable until tx_ready
//    tx_ready          sink accepts the current word
//    overflow          sticky: a commit arrived while the FIFO was full
//    done              the HALT record has been completely sent
// -----------------------------------------------------------------------------
module commit_trace_tx #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        commit_valid,
   input  logic [15:0] commit_pc,
   input  logic        commit_regwrite,
   input  logic [3:0]  commit_reg,
   input  logic [15:0] commit_wdata,
   input  logic        commit_memread,
   input  logic        commit_memwrite,
   input  logic [15:0] commit_addr,
   input  logic [15:0] commit_mdata,
   input  logic        commit_halt,
   output logic        commit_stall,
   output logic        tx_valid,
   output logic [15:0] tx_data,
   input  logic        tx_ready,
   output logic        overflow,
   output logic        done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   localparam logic [3:0] T_NOP   = 4'h0;
   localparam logic [3:0] T_REG   = 4'h1;
   localparam logic [3:0] T_LOAD  = 4'h2;
   localparam logic [3:0] T_STORE = 4'h3;
   localparam logic [3:0] T_HALT  = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_W1   = 3'd2,
      S_W2   = 3'd3,
      S_W3   = 3'd4,
      S_DONE = 3'd5
   } state_e;

   // A record is stored fully formatted so the serializer only selects words.
   // last = index of the final word (1..3), halt marks the terminating record.
   typedef struct packed {
      logic [15:0] hdr;
      logic [15:0] pc;
      logic [15:0] w2;
      logic [15:0] w3;
      logic [1:0]  last;
      logic        halt;
   } rec_t;

   // word index currently on the bus for a given serializer state
   function automatic logic [1:0] state_idx(input state_e s);
      case (s)
         S_W1:    return 2'd1;
         S_W2:    return 2'd2;
         S_W3:    return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic state_e idx_state(input logic [1:0] idx);
      case (idx)
         2'd1:    return S_W1;
         2'd2:    return S_W2;
         2'd3:    return S_W3;
         default: return S_HDR;
      endcase
   endfunction

   function automatic logic [15:0] word_at(input rec_t r, input logic [1:0] idx);
      case (idx)
         2'd1:    return r.pc;
         2'd2:    return r.w2;
         2'd3:    return r.w3;
         default: return r.hdr;
      endcase
   endfunction

   // ---------------------------------------------------------------- state
   rec_t             mem_q [0:DEPTH-1];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halt_seen_q, halt_seen_d;
   logic             overflow_q, overflow_d;
   state_e           state_q, state_d;
   rec_t             cur_q, cur_d;
   logic             tx_valid_q, tx_valid_d;
   logic [15:0]      tx_data_q, tx_data_d;
   logic             done_q, done_d;

   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;
   logic [15:0]      inum16_s;
   rec_t             new_rec_s;
   logic [1:0]       idx_s;

   // Counter value as it appears in the HALT record: zero-extended or truncated
   if (CNT_W >= 16) begin : g_inum_trunc
      assign inum16_s = cnt_q[15:0];
   end else begin : g_inum_ext
      assign inum16_s = {{(16-CNT_W){1'b0}}, cnt_q};
   end

   // Full/empty come from the occupancy register only, so a same-cycle pop
   // never unblocks a push.
   assign full_s  = (count_q == FULL_CNT);
   assign empty_s = (count_q == {(PTR_W+1){1'b0}});
   assign push_s  = commit_valid & ~full_s & ~halt_seen_q;
   assign idx_s   = state_idx(state_q);

   // Classify the retiring instruction and format its record (first match wins)
   always_comb begin
      new_rec_s      = {$bits(rec_t){1'b0}};
      new_rec_s.pc   = commit_pc;
      if (commit_halt) begin
         new_rec_s.hdr  = {T_HALT, 4'h0, inum16_s[7:0]};
         new_rec_s.w2   = inum16_s;
         new_rec_s.last = 2'd2;
         new_rec_s.halt = 1'b1;
      end else if (commit_regwrite & commit_memread) begin
         new_rec_s.hdr  = {T_LOAD, commit_reg, inum16_s[7:0]};
         new_rec_s.w2   = commit_wdata;
         new_rec_s.w3   = commit_addr;
         new_rec_s.last = 2'd3;
      end else if (commit_regwrite) begin
         new_rec_s.hdr  = {T_REG, commit_reg, inum16_s[7:0]};
         new_rec_s.w2   = commit_wdata;
         new_rec_s.last = 2'd2;
      end else if (commit_memwrite) begin
         new_rec_s.hdr  = {T_STORE, 4'h0, inum16_s[7:0]};
         new_rec_s.w2   = commit_addr;
         new_rec_s.w3   = commit_mdata;
         new_rec_s.last = 2'd3;
      end else begin
         new_rec_s.hdr  = {T_NOP, 4'h0, inum16_s[7:0]};
         new_rec_s.last = 2'd1;
      end
   end

   // Serializer next state: load from FIFO head, step words on handshake
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      done_d     = done_q;
      pop_s      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_s) begin
               pop_s      = 1'b1;
               cur_d      = mem_q[rd_ptr_q];
               tx_valid_d = 1'b1;
               tx_data_d  = mem_q[rd_ptr_q].hdr;
               state_d    = S_HDR;
            end else begin
               tx_valid_d = 1'b0;
            end
         end
         S_HDR, S_W1, S_W2, S_W3: begin
            if (tx_ready) begin
               if (idx_s == cur_q.last) begin
                  if (cur_q.halt) begin
                     state_d    = S_DONE;
                     tx_valid_d = 1'b0;
                     done_d     = 1'b1;
                  end else if (!empty_s) begin
                     // back-to-back records: next header with no bubble
                     pop_s      = 1'b1;
                     cur_d      = mem_q[rd_ptr_q];
                     tx_valid_d = 1'b1;
                     tx_data_d  = mem_q[rd_ptr_q].hdr;
                     state_d    = S_HDR;
                  end else begin
                     state_d    = S_IDLE;
                     tx_valid_d = 1'b0;
                  end
               end else begin
                  state_d    = idx_state(idx_s + 2'd1);
                  tx_data_d  = word_at(cur_q, idx_s + 2'd1);
                  tx_valid_d = 1'b1;
               end
            end else begin
               // sink stalled: hold the current word
               state_d    = state_q;
               tx_valid_d = tx_valid_q;
            end
         end
         S_DONE: begin
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
         end
         default: begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   // FIFO pointers, occupancy, instruction counter and sticky flags
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      cnt_d       = cnt_q;
      halt_seen_d = halt_seen_q;
      overflow_d  = overflow_q;
      if (push_s) begin
         wr_ptr_d    = wr_ptr_q + PTR_W'(1);
         cnt_d       = cnt_q + CNT_W'(1);
         halt_seen_d = halt_seen_q | commit_halt;
      end else begin
         wr_ptr_d    = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
      // commits after HALT are ignored silently, not counted as drops
      if (commit_valid & full_s & ~halt_seen_q) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Record storage; contents need no reset since occupancy guards reads
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= new_rec_s;
      end
   end

   // Control and serializer registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= {PTR_W{1'b0}};
         rd_ptr_q    <= {PTR_W{1'b0}};
         count_q     <= {(PTR_W+1){1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         halt_seen_q <= 1'b0;
         overflow_q  <= 1'b0;
         state_q     <= S_IDLE;
         cur_q       <= {$bits(rec_t){1'b0}};
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 16'h0000;
         done_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cnt_q       <= cnt_d;
         halt_seen_q <= halt_seen_d;
         overflow_q  <= overflow_d;
         state_q     <= state_d;
         cur_q       <= cur_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         done_q      <= done_d;
      end
   end

   assign commit_stall = full_s;
   assign tx_valid     = tx_valid_q;
   assign tx_data      = tx_data_q;
   assign overflow     = overflow_q;
   assign done         = done_q;

endmodule
